// File: rtl/fft_pkg.sv
// Shared types and widths for the FFT bin-stream consumers.
// Complex bins are packed {re, im} so a cplx_t overlays the 80-bit bus directly.
package fft_pkg;

    localparam int DATA_W = 40;
    localparam int MAG_W  = 41;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    // Two's-complement magnitude; the most negative input maps to 2^(DATA_W-1) exactly.
    function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] u;
        u = x;
        if (x[DATA_W-1]) begin
            abs_val = ~u + DATA_W'(1);
        end else begin
            abs_val = u;
        end
    endfunction

endpackage

// File: rtl/cplx_mag.sv
// Three-stage alpha-max-plus-beta-min magnitude: |re|,|im| -> max/min -> max + 3*min/8.
module cplx_mag
    import fft_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  cplx_t            in_data,
    input  logic             in_valid,
    output logic [MAG_W-1:0] out_mag,
    output logic             out_valid
);

    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] mx_q, mx_d, mn_q, mn_d;
    logic [MAG_W-1:0]  mag_q, mag_d;
    logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [DATA_W+1:0] mn3_s;

    always_comb begin
        a_d  = abs_val(in_data.re);
        b_d  = abs_val(in_data.im);
        v1_d = in_valid;
        if (a_q >= b_q) begin
            mx_d = a_q;
            mn_d = b_q;
        end else begin
            mx_d = b_q;
            mn_d = a_q;
        end
        v2_d  = v1_q;
        // 3*mn needs 42 bits; after >>3 it always fits beside mx in 41 bits.
        mn3_s = {2'b00, mn_q} + {1'b0, mn_q, 1'b0};
        mag_d = {1'b0, mx_q} + MAG_W'(mn3_s >> 3);
        v3_d  = v2_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q   <= {DATA_W{1'b0}};
            b_q   <= {DATA_W{1'b0}};
            mx_q  <= {DATA_W{1'b0}};
            mn_q  <= {DATA_W{1'b0}};
            mag_q <= {MAG_W{1'b0}};
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            mx_q  <= mx_d;
            mn_q  <= mn_d;
            mag_q <= mag_d;
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
        end
    end

    assign out_mag   = mag_q;
    assign out_valid = v3_q;

endmodule

// File: rtl/fft_mag_peak.sv
// Magnitude stream plus per-frame windowed peak search over the FFT bin stream.
// Bin index and frame flags ride a 3-deep delay line alongside the magnitude pipe.
module fft_mag_peak
    import fft_pkg::*;
#(
    parameter int BIN_W     = 10,
    parameter int SEARCH_LO = 1,
    parameter int SEARCH_HI = 511
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [79:0]      din,
    input  logic             din_valid,
    input  logic             start,
    input  logic             stop,
    output logic [MAG_W-1:0] mag,
    output logic             mag_valid,
    output logic [BIN_W-1:0] mag_bin,
    output logic             mag_start,
    output logic             mag_stop,
    output logic [MAG_W-1:0] peak_mag,
    output logic [BIN_W-1:0] peak_bin,
    output logic             peak_valid
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SEARCH = 1'b1;

    localparam logic [BIN_W-1:0] WIN_LO = BIN_W'(SEARCH_LO);
    localparam logic [BIN_W-1:0] WIN_HI = BIN_W'(SEARCH_HI);

    cplx_t             din_c;
    logic [MAG_W-1:0]  mag_s;
    logic              mag_valid_s;

    logic [BIN_W-1:0]  bin_cnt_q, bin_cnt_d, bin_now_s;
    logic [2:0][BIN_W-1:0] bin_pipe_q, bin_pipe_d;
    logic [2:0]        start_pipe_q, start_pipe_d;
    logic [2:0]        stop_pipe_q, stop_pipe_d;

    logic [0:0]        state_q, state_d;
    logic [MAG_W-1:0]  best_mag_q, best_mag_d, peak_mag_q, peak_mag_d;
    logic [BIN_W-1:0]  best_bin_q, best_bin_d, peak_bin_q, peak_bin_d;
    logic              peak_valid_q, peak_valid_d;

    logic              in_win_s;
    logic [MAG_W-1:0]  cand_mag_s, upd_mag_s;
    logic [BIN_W-1:0]  cand_bin_s, upd_bin_s;

    assign din_c = din;

    cplx_mag u_cplx_mag (
        .clock     (clock),
        .reset     (reset),
        .in_data   (din_c),
        .in_valid  (din_valid),
        .out_mag   (mag_s),
        .out_valid (mag_valid_s)
    );

    // Flags are gated with din_valid at entry so they can never outrun mag_valid.
    always_comb begin
        if (start) begin
            bin_now_s = {BIN_W{1'b0}};
        end else begin
            bin_now_s = bin_cnt_q;
        end
        if (din_valid) begin
            bin_cnt_d = bin_now_s + BIN_W'(1);
        end else begin
            bin_cnt_d = bin_cnt_q;
        end
        bin_pipe_d   = {bin_pipe_q[1:0], bin_now_s};
        start_pipe_d = {start_pipe_q[1:0], din_valid & start};
        stop_pipe_d  = {stop_pipe_q[1:0], din_valid & stop};
    end

    always_comb begin
        in_win_s = (bin_pipe_q[2] >= WIN_LO) && (bin_pipe_q[2] <= WIN_HI);
        if (in_win_s) begin
            cand_mag_s = mag_s;
            cand_bin_s = bin_pipe_q[2];
        end else begin
            cand_mag_s = {MAG_W{1'b0}};
            cand_bin_s = WIN_LO;
        end
        // Strictly greater only, so ties keep the earlier bin.
        if (in_win_s && (mag_s > best_mag_q)) begin
            upd_mag_s = mag_s;
            upd_bin_s = bin_pipe_q[2];
        end else begin
            upd_mag_s = best_mag_q;
            upd_bin_s = best_bin_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        best_mag_d   = best_mag_q;
        best_bin_d   = best_bin_q;
        peak_mag_d   = peak_mag_q;
        peak_bin_d   = peak_bin_q;
        peak_valid_d = 1'b0;
        if (mag_valid_s && start_pipe_q[2]) begin
            // A start in any state (re)loads the best; an open frame is dropped unreported.
            best_mag_d = cand_mag_s;
            best_bin_d = cand_bin_s;
            if (stop_pipe_q[2]) begin
                peak_mag_d   = cand_mag_s;
                peak_bin_d   = cand_bin_s;
                peak_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end else begin
                state_d = ST_SEARCH;
            end
        end else if (mag_valid_s) begin
            case (state_q)
                ST_SEARCH: begin
                    best_mag_d = upd_mag_s;
                    best_bin_d = upd_bin_s;
                    if (stop_pipe_q[2]) begin
                        peak_mag_d   = upd_mag_s;
                        peak_bin_d   = upd_bin_s;
                        peak_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bin_cnt_q    <= {BIN_W{1'b0}};
            bin_pipe_q   <= {3*BIN_W{1'b0}};
            start_pipe_q <= 3'b000;
            stop_pipe_q  <= 3'b000;
            state_q      <= ST_IDLE;
            best_mag_q   <= {MAG_W{1'b0}};
            best_bin_q   <= {BIN_W{1'b0}};
            peak_mag_q   <= {MAG_W{1'b0}};
            peak_bin_q   <= {BIN_W{1'b0}};
            peak_valid_q <= 1'b0;
        end else begin
            bin_cnt_q    <= bin_cnt_d;
            bin_pipe_q   <= bin_pipe_d;
            start_pipe_q <= start_pipe_d;
            stop_pipe_q  <= stop_pipe_d;
            state_q      <= state_d;
            best_mag_q   <= best_mag_d;
            best_bin_q   <= best_bin_d;
            peak_mag_q   <= peak_mag_d;
            peak_bin_q   <= peak_bin_d;
            peak_valid_q <= peak_valid_d;
        end
    end

    assign mag        = mag_s;
    assign mag_valid  = mag_valid_s;
    assign mag_bin    = bin_pipe_q[2];
    assign mag_start  = start_pipe_q[2];
    assign mag_stop   = stop_pipe_q[2];
    assign peak_mag   = peak_mag_q;
    assign peak_bin   = peak_bin_q;
    assign peak_valid = peak_valid_q;

endmodule

// File: tb/tb_fft_mag_peak.sv
// Directed bench for fft_mag_peak: one default-window instance and one with window 1..6.
module tb_fft_mag_peak;

    logic        clock;
    logic        reset;
    logic [79:0] din;
    logic        din_valid;
    logic        start;
    logic        stop;

    logic [40:0] mag_a, peak_mag_a, mag_b, peak_mag_b;
    logic [9:0]  mag_bin_a, peak_bin_a, mag_bin_b, peak_bin_b;
    logic        mag_valid_a, mag_start_a, mag_stop_a, peak_valid_a;
    logic        mag_valid_b, mag_start_b, mag_stop_b, peak_valid_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int pv_cnt_a = 0, pv_cyc_a = 0, pv_cnt_b = 0, pv_cyc_b = 0;
    logic [40:0] pk_mag_a, pk_mag_b;
    logic [9:0]  pk_bin_a, pk_bin_b;
    bit mon_en = 1'b0;
    int exp_bin = 0;
    int mon_cnt = 0;

    fft_mag_peak #(.BIN_W(10), .SEARCH_LO(1), .SEARCH_HI(511)) dut_a (
        .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
        .start(start), .stop(stop), .mag(mag_a), .mag_valid(mag_valid_a),
        .mag_bin(mag_bin_a), .mag_start(mag_start_a), .mag_stop(mag_stop_a),
        .peak_mag(peak_mag_a), .peak_bin(peak_bin_a), .peak_valid(peak_valid_a)
    );

    fft_mag_peak #(.BIN_W(10), .SEARCH_LO(1), .SEARCH_HI(6)) dut_b (
        .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
        .start(start), .stop(stop), .mag(mag_b), .mag_valid(mag_valid_b),
        .mag_bin(mag_bin_b), .mag_start(mag_start_b), .mag_stop(mag_stop_b),
        .peak_mag(peak_mag_b), .peak_bin(peak_bin_b), .peak_valid(peak_valid_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Peak-report recorder and bin-order checker, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (peak_valid_a) begin
                pv_cnt_a++;
                pk_mag_a = peak_mag_a;
                pk_bin_a = peak_bin_a;
                pv_cyc_a = cyc;
            end
            if (peak_valid_b) begin
                pv_cnt_b++;
                pk_mag_b = peak_mag_b;
                pk_bin_b = peak_bin_b;
                pv_cyc_b = cyc;
            end
            if (mon_en && mag_valid_a) begin
                if (mag_start_a) exp_bin = 0;
                check_val("mag_bin_order", 64'(mag_bin_a), 64'(exp_bin));
                exp_bin++;
                mon_cnt++;
            end
        end
    end

    task automatic drive(input logic v, input logic signed [39:0] re, input logic signed [39:0] im,
                         input logic s, input logic p);
        @(posedge clock);
        #1;
        din_valid = v;
        din       = {re, im};
        start     = s;
        stop      = p;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 40'sd0, 40'sd0, 1'b0, 1'b0);
    endtask

    task automatic check_zero_a(input string tag);
        check_val({tag, "_mag"},        64'(mag_a),        64'd0);
        check_val({tag, "_mag_valid"},  64'(mag_valid_a),  64'd0);
        check_val({tag, "_mag_bin"},    64'(mag_bin_a),    64'd0);
        check_val({tag, "_mag_start"},  64'(mag_start_a),  64'd0);
        check_val({tag, "_mag_stop"},   64'(mag_stop_a),   64'd0);
        check_val({tag, "_peak_mag"},   64'(peak_mag_a),   64'd0);
        check_val({tag, "_peak_bin"},   64'(peak_bin_a),   64'd0);
        check_val({tag, "_peak_valid"}, 64'(peak_valid_a), 64'd0);
    endtask

    logic signed [39:0] re_tab [4];
    logic signed [39:0] im_tab [4];
    logic [63:0]        exp_tab [4];
    int mags8 [8];
    int stop_cyc;
    int pa0, pb0;

    initial begin
        reset = 1'b1; din = 80'd0; din_valid = 1'b0; start = 1'b0; stop = 1'b0;
        re_tab[0] = 40'sd3;              im_tab[0] = -40'sd4; exp_tab[0] = 64'd5;
        re_tab[1] = 40'sh80_0000_0000;   im_tab[1] = 40'sd0;  exp_tab[1] = 64'd549755813888;
        re_tab[2] = 40'sd8;              im_tab[2] = 40'sd8;  exp_tab[2] = 64'd11;
        re_tab[3] = 40'sd0;              im_tab[3] = 40'sd0;  exp_tab[3] = 64'd0;
        mags8[0] = 900; mags8[1] = 5; mags8[2] = 40; mags8[3] = 40;
        mags8[4] = 7;   mags8[5] = 12; mags8[6] = 3; mags8[7] = 800;

        // Reset state
        idle(3);
        check_zero_a("rst");
        drive(1'b0, 40'sd0, 40'sd0, 1'b0, 1'b0);
        reset = 1'b0;
        idle(2);

        // Magnitude values and 3-cycle latency
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, re_tab[k], im_tab[k], 1'b0, 1'b0);
            idle(2);
            check_val("lat_early_valid", 64'(mag_valid_a), 64'd0);
            idle(1);
            check_val("mag_value", 64'(mag_a), exp_tab[k]);
            check_val("lat_valid", 64'(mag_valid_a), 64'd1);
            idle(1);
            check_val("lat_late_valid", 64'(mag_valid_a), 64'd0);
        end
        idle(4);
        check_val("no_report_without_start", 64'(pv_cnt_a), 64'd0);

        // Eight-bin frame against window 1..6
        pa0 = pv_cnt_a; pb0 = pv_cnt_b;
        for (int j = 0; j < 8; j++)
            drive(1'b1, 40'(mags8[j]), 40'sd0, j == 0, j == 7);
        stop_cyc = cyc;
        idle(8);
        check_val("f8_b_reports", 64'(pv_cnt_b - pb0), 64'd1);
        check_val("f8_b_peak_bin", 64'(pk_bin_b), 64'd2);
        check_val("f8_b_peak_mag", 64'(pk_mag_b), 64'd40);
        check_val("f8_b_peak_cycle", 64'(pv_cyc_b), 64'(stop_cyc + 4));
        check_val("f8_b_held_bin", 64'(peak_bin_b), 64'd2);
        check_val("f8_a_peak_bin", 64'(pk_bin_a), 64'd7);
        check_val("f8_a_peak_mag", 64'(pk_mag_a), 64'd800);
        check_val("f8_a_reports", 64'(pv_cnt_a - pa0), 64'd1);

        // Bursty 1024-bin frame with DC energy and a tone at bin 100
        pa0 = pv_cnt_a;
        mon_en = 1'b1; mon_cnt = 0; exp_bin = 0;
        for (int i = 0; i < 1024; i++) begin
            drive(1'b1, (i == 100) ? 40'sd2000 : ((i == 0) ? 40'sd9000 : 40'(i % 7)),
                  40'sd0, i == 0, i == 1023);
            if (i == 1023) stop_cyc = cyc;
            idle(1);
        end
        idle(6);
        mon_en = 1'b0;
        check_val("burst_beats", 64'(mon_cnt), 64'd1024);
        check_val("burst_reports", 64'(pv_cnt_a - pa0), 64'd1);
        check_val("burst_peak_bin", 64'(pk_bin_a), 64'd100);
        check_val("burst_peak_mag", 64'(pk_mag_a), 64'd2000);
        check_val("burst_peak_cycle", 64'(pv_cyc_a), 64'(stop_cyc + 4));

        // Restart at bin 300 abandons the first frame
        pa0 = pv_cnt_a;
        for (int i = 0; i < 300; i++)
            drive(1'b1, (i == 50) ? 40'sd700 : 40'sd1, 40'sd0, i == 0, 1'b0);
        for (int j = 0; j < 8; j++)
            drive(1'b1, (j == 3) ? 40'sd300 : 40'sd2, 40'sd0, j == 0, j == 7);
        stop_cyc = cyc;
        idle(8);
        check_val("restart_reports", 64'(pv_cnt_a - pa0), 64'd1);
        check_val("restart_peak_bin", 64'(pk_bin_a), 64'd3);
        check_val("restart_peak_mag", 64'(pk_mag_a), 64'd300);
        check_val("restart_peak_cycle", 64'(pv_cyc_a), 64'(stop_cyc + 4));

        // Reset while a stop beat is still in flight
        pa0 = pv_cnt_a;
        for (int j = 0; j < 10; j++)
            drive(1'b1, 40'(j + 1), 40'sd0, j == 0, j == 9);
        @(posedge clock);
        #1;
        din_valid = 1'b0; start = 1'b0; stop = 1'b0; reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_zero_a("midrst");
        idle(8);
        check_val("midrst_no_report", 64'(pv_cnt_a - pa0), 64'd0);

        // Single-bin frame at bin 0: DC is outside the default window
        pa0 = pv_cnt_a;
        drive(1'b1, 40'sd500, 40'sd0, 1'b1, 1'b1);
        stop_cyc = cyc;
        idle(6);
        check_val("single_reports", 64'(pv_cnt_a - pa0), 64'd1);
        check_val("single_peak_mag", 64'(pk_mag_a), 64'd0);
        check_val("single_peak_bin", 64'(pk_bin_a), 64'd1);
        check_val("single_peak_cycle", 64'(pv_cyc_a), 64'(stop_cyc + 4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_mag_peak.md
# fft_mag_peak

Downstream consumer of the `fft` block's complex bin stream. It converts each 80-bit complex bin to an approximate magnitude using alpha-max-plus-beta-min, and streams the magnitudes onward. It also tracks the strongest bin inside a programmable search window on every frame and reports that bin's index and magnitude once per frame. It feeds spectrum display and tone-detection logic.

## Interface
- `BIN_W`, default 10: bin index width; the frame holds at most 2^BIN_W bins.
- `SEARCH_LO`, default 1: lowest bin index eligible for peak search. The default excludes DC.
- `SEARCH_HI`, default 511: highest bin index eligible for peak search, inclusive.
- `clock` in, 1 bit: single clock. All logic is rising-edge.
- `reset` in, 1 bit: synchronous, active-high.
- `din` in, 80 bits: complex bin. `din[79:40]` is signed real; `din[39:0]` is signed imaginary.
- `din_valid` in, 1 bit: qualifies `din`, `start` and `stop`.
- `start` in, 1 bit: high with the first bin of a frame.
- `stop` in, 1 bit: high with the last bin of a frame.
- `mag` out, 41 bits: unsigned magnitude.
- `mag_valid` out, 1 bit: qualifies `mag`, `mag_bin`, `mag_start` and `mag_stop`.
- `mag_bin` out, `BIN_W` bits: index of the bin within its frame.
- `mag_start` out, 1 bit: delayed copy of `start`.
- `mag_stop` out, 1 bit: delayed copy of `stop`.
- `peak_mag` out, 41 bits: largest in-window magnitude of the last completed frame.
- `peak_bin` out, `BIN_W` bits: index of that bin.
- `peak_valid` out, 1 bit: one-cycle pulse marking a new peak result.

## Operation
- **Magnitude pipeline**
  - Stage 1 computes `a=|re|` and `b=|im|` as 40-bit unsigned values. `|-2^39| = 2^39` is exact.
  - Stage 2 computes `mx=max(a,b)` and `mn=min(a,b)`.
  - Stage 3 computes `mag = mx + ((3*mn) >> 3)`. `3*mn` is held at 42 bits and the result truncates toward zero. Nothing saturates, because 41 bits is sufficient.
- **Bin counter**
  - Loads 0 on a valid `start` beat.
  - Increments on every other valid beat and wraps modulo 2^BIN_W.
  - Travels down the pipeline with the data as `mag_bin`.
- **Peak search FSM** on the stage-3 output, with states IDLE and SEARCH.
  - IDLE: a valid `mag_start` loads the running best with (`mag`, `mag_bin`) if the bin is in-window, else with (0, `SEARCH_LO`). The FSM then goes to SEARCH.
  - Valid beats in IDLE without `mag_start` are ignored.
  - SEARCH: an in-window bin replaces the running best only if it is strictly greater. Ties keep the earlier bin.
  - SEARCH, on a valid `mag_stop`: that beat is evaluated first. Then `peak_mag`/`peak_bin` are updated, `peak_valid` pulses, and the FSM goes to IDLE.
  - SEARCH, on a valid `mag_start`: the frame is abandoned with no `peak_valid`, and the best is reloaded as in IDLE.
  - `start` and `stop` on the same beat form a one-bin frame: load, then report immediately.
- **Window**
  - In-window means `SEARCH_LO <= mag_bin <= SEARCH_HI`.
  - An empty window reports `peak_mag=0` and `peak_bin=SEARCH_LO`.
- **No backpressure.** The block accepts a beat on every cycle. Gaps in `din_valid` are permitted anywhere.

## Timing
- **Latency:** `din` at cycle t appears on `mag` at t+3. `mag_valid` is `din_valid` delayed by 3.
- **Peak report:** the frame's stop beat at input cycle t gives `peak_valid` high for exactly cycle t+4.
  - New `peak_mag`/`peak_bin` values are visible in that same cycle and held until the next report.
- **Reset values:**
  - All valid, start and stop outputs: 0.
  - `mag`, `mag_bin`, `peak_mag`: 0.
  - `peak_bin`: 0.
  - FSM: IDLE. Bin counter: 0.
- **Reset mid-frame:** all pipeline contents are dropped. No `peak_valid` is produced for that partial frame.
- **Data gating:** data registers may update on invalid beats, but valid and flag outputs must never assert without a corresponding valid input.

## Structure
- Package `fft_pkg` holds:
  - `DATA_W=40` and `MAG_W=41`.
  - `typedef struct packed {logic signed [39:0] re; logic signed [39:0] im;} cplx_t`. Its packing matches `din`.
- Sub-module `cplx_mag` contains the three-stage magnitude pipeline only: `cplx_t` in, `MAG_W` out, with a valid sideband.
- The top level holds the bin counter, the sideband delay line and the peak FSM.

## Test plan
- **Basic magnitude:** re=3, im=-4 with valid at cycle 0 -> `mag=5` with `mag_valid` at cycle 3.
- **Arithmetic edges:**
  - re=-2^39, im=0 -> `mag=2^39`.
  - re=8, im=8 -> `mag=11`.
  - re=im=0 -> `mag=0`.
- **Eight-bin frame with window limits:** frame of 8 bins, `SEARCH_LO=1`, `SEARCH_HI=6`, bin magnitudes {900,5,40,40,7,12,3,800} -> `peak_bin=2`, `peak_mag=40`, with `peak_valid` 4 cycles after stop. This checks DC excluded, tie goes to the earlier bin, and bin 7 out of window.
- **Bursty input:** 1024-bin frame with `din_valid` toggling every cycle and a tone at bin 100 -> `mag_bin` runs 0..1023 in order, and the report is `peak_bin=100`.
- **Restart and reset:**
  - A second `start` at bin 300 of a frame -> no report for the first frame; the second frame reports normally.
  - `reset` asserted mid-frame -> all outputs are 0 on the next cycle and no `peak_valid` is produced.
- **Single-bin and empty-window frames:**
  - Single-bin frame (`start` and `stop` together) at bin 0 with default window -> `peak_mag=0`, `peak_bin=1`, `peak_valid` at t+4.
